// File: rtl/range_unwrapper_if.sv
// Stream interface for range_unwrapper.
// Purpose : carries the wrapped-sample input handshake, the unwrapped-result
//           output handshake, the synchronous clear and the status flags.
// Signals : clr       - synchronous clear back to the no-history state
//           in_valid  - input sample valid
//           in_ready  - block can accept a sample this cycle
//           in_val    - wrapped sample, legal range 0..MOD-1
//           out_valid - out_val holds a result
//           out_ready - consumer accepts out_val
//           out_val   - signed unwrapped value
//           err       - one-cycle pulse after an illegal sample is consumed
//           sat       - sticky accumulator-clamped flag
//           wrap_cnt  - count of +/-MOD corrections (0 when stats are not built)
// Modports: master drives the stimulus side, slave is the unwrapper.
interface range_unwrapper_if #(
    parameter int unsigned DW_IN  = 7,
    parameter int unsigned DW_OUT = 10
);
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [DW_IN-1:0]  in_val;
    logic              out_valid;
    logic              out_ready;
    logic [DW_OUT-1:0] out_val;
    logic              err;
    logic              sat;
    logic [7:0]        wrap_cnt;

    modport master (
        output clr, in_valid, in_val, out_ready,
        input  in_ready, out_valid, out_val, err, sat, wrap_cnt
    );

    modport slave (
        input  clr, in_valid, in_val, out_ready,
        output in_ready, out_valid, out_val, err, sat, wrap_cnt
    );
endinterface

// File: rtl/range_unwrapper.sv
// range_unwrapper: recovers a continuous signed value from a stream of
// modulo-MOD wrapped samples. Each step takes the shortest-path difference to
// the previous sample (|delta| > WRAP_TH is corrected by +/-MOD) and adds it to
// a running accumulator that clamps to the signed DW_OUT-bit range.
// Ports : clk   - system clock, rising edge
//         rst_n - asynchronous active-low reset
//         bus   - range_unwrapper_if slave (handshakes, clear, status flags)
// Build option: define RANGE_UNWRAP_STATS_EN to build the saturating 8-bit
// wrap-correction counter on bus.wrap_cnt; otherwise wrap_cnt is tied to 0.
module range_unwrapper #(
    parameter int unsigned MOD     = 100,
    parameter int unsigned WRAP_TH = 50,
    parameter int unsigned DW_IN   = 7,
    parameter int unsigned DW_OUT  = 10
) (
    input logic               clk,
    input logic               rst_n,
    range_unwrapper_if.slave  bus
);
    localparam logic        [DW_IN:0]  L_MOD_U = (DW_IN + 1)'(MOD);
    localparam logic signed [DW_IN:0]  L_MOD   = (DW_IN + 1)'(MOD);
    localparam logic signed [DW_IN:0]  L_TH    = (DW_IN + 1)'(WRAP_TH);
    localparam logic signed [DW_OUT:0] L_MAX   = (DW_OUT + 1)'((2 ** (DW_OUT - 1)) - 1);
    localparam logic signed [DW_OUT:0] L_MIN   = -(DW_OUT + 1)'(2 ** (DW_OUT - 1));

    typedef enum logic {ST_EMPTY, ST_TRACK} state_t;

    state_t                    r_state,     w_state_nxt;
    logic signed [DW_OUT-1:0]  r_acc,       w_acc_nxt;
    logic        [DW_IN-1:0]   r_prev,      w_prev_nxt;
    logic                      r_out_valid, w_out_valid_nxt;
    logic                      r_err,       w_err_nxt;
    logic                      r_sat,       w_sat_nxt;

    logic                      w_in_ready;
    logic                      w_accept;
    logic                      w_legal;
    logic                      w_wrap_hi;
    logic                      w_wrap_lo;
    logic                      w_track_upd;
    logic signed [DW_IN:0]     w_delta_raw;
    logic signed [DW_IN:0]     w_delta;
    logic signed [DW_OUT:0]    w_sum;
    logic signed [DW_OUT-1:0]  w_acc_clamped;
    logic                      w_clip;

    assign w_in_ready = !bus.clr && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_legal    = {1'b0, bus.in_val} < L_MOD_U;

    // Both operands are < MOD, so the raw difference fits in DW_IN+1 signed bits.
    assign w_delta_raw = $signed({1'b0, bus.in_val}) - $signed({1'b0, r_prev});
    assign w_wrap_hi   = w_delta_raw > L_TH;
    assign w_wrap_lo   = w_delta_raw < -L_TH;
    assign w_delta     = w_wrap_hi ? (w_delta_raw - L_MOD) :
                         w_wrap_lo ? (w_delta_raw + L_MOD) : w_delta_raw;

    // One extra bit of headroom so the clamp sees the true sum.
    assign w_sum = (DW_OUT + 1)'(r_acc) + (DW_OUT + 1)'(w_delta);

    always_comb begin
        w_clip        = 1'b0;
        w_acc_clamped = DW_OUT'(w_sum);
        if (w_sum > L_MAX) begin
            w_clip        = 1'b1;
            w_acc_clamped = DW_OUT'(L_MAX);
        end else if (w_sum < L_MIN) begin
            w_clip        = 1'b1;
            w_acc_clamped = DW_OUT'(L_MIN);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_prev_nxt      = r_prev;
        w_out_valid_nxt = r_out_valid;
        w_sat_nxt       = r_sat;
        w_err_nxt       = 1'b0;
        w_track_upd     = 1'b0;

        if (r_out_valid && bus.out_ready) begin
            w_out_valid_nxt = 1'b0;
        end

        if (bus.clr) begin
            // Clear wins over everything, including a pending result.
            w_state_nxt     = ST_EMPTY;
            w_acc_nxt       = '0;
            w_prev_nxt      = '0;
            w_out_valid_nxt = 1'b0;
            w_sat_nxt       = 1'b0;
        end else if (w_accept) begin
            if (!w_legal) begin
                // Illegal samples are swallowed: flag only, no history change.
                w_err_nxt = 1'b1;
            end else begin
                w_prev_nxt      = bus.in_val;
                w_out_valid_nxt = 1'b1;
                unique case (r_state)
                    ST_EMPTY: begin
                        w_acc_nxt   = DW_OUT'(bus.in_val);
                        w_state_nxt = ST_TRACK;
                    end
                    ST_TRACK: begin
                        w_track_upd = 1'b1;
                        w_acc_nxt   = w_acc_clamped;
                        if (w_clip) begin
                            w_sat_nxt = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_acc       <= '0;
            r_prev      <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_prev      <= w_prev_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_err       <= w_err_nxt;
            r_sat       <= w_sat_nxt;
        end
    end

`ifdef RANGE_UNWRAP_STATS_EN
    logic [7:0] r_wrap_cnt;
    logic       w_wrapped;

    assign w_wrapped = w_wrap_hi || w_wrap_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap_cnt <= '0;
        end else if (bus.clr) begin
            r_wrap_cnt <= '0;
        end else if (w_track_upd && w_wrapped && (r_wrap_cnt != 8'hFF)) begin
            r_wrap_cnt <= r_wrap_cnt + 8'd1;
        end
    end

    assign bus.wrap_cnt = r_wrap_cnt;
`else
    assign bus.wrap_cnt = '0;
`endif

    // The accumulator only moves on an accepted sample, which needs the
    // current result to be consumed first, so it doubles as the held output.
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_val   = r_acc;
    assign bus.err       = r_err;
    assign bus.sat       = r_sat;
endmodule

// File: tb/tb_range_unwrapper.sv
// Self-checking bench for range_unwrapper: directed stimulus, a reference
// model feeding a scoreboard queue, and a monitor that pops on every
// consumed result.
module tb_range_unwrapper;
    localparam int unsigned DW_IN  = 7;
    localparam int unsigned DW_OUT = 10;
`ifdef RANGE_UNWRAP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    range_unwrapper_if #(.DW_IN(DW_IN), .DW_OUT(DW_OUT)) bus ();

    range_unwrapper #(
        .MOD     (100),
        .WRAP_TH (50),
        .DW_IN   (DW_IN),
        .DW_OUT  (DW_OUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int sb[$];

    // Reference model state
    int m_acc;
    int m_prev;
    bit m_empty;
    bit m_sat;
    int m_wraps;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        m_empty = 1'b1;
        m_acc   = 0;
        m_prev  = 0;
        m_sat   = 1'b0;
        m_wraps = 0;
    endfunction

    function automatic int model_step(input int s);
        int d;
        int a;
        if (m_empty) begin
            m_empty = 1'b0;
            m_acc   = s;
            m_prev  = s;
            return s;
        end
        d = s - m_prev;
        if (d > 50) begin
            d -= 100;
            if (m_wraps < 255) m_wraps++;
        end else if (d < -50) begin
            d += 100;
            if (m_wraps < 255) m_wraps++;
        end
        a = m_acc + d;
        if (a > 511) begin
            a = 511;
            m_sat = 1'b1;
        end else if (a < -512) begin
            a = -512;
            m_sat = 1'b1;
        end
        m_acc  = a;
        m_prev = s;
        return a;
    endfunction

    // Monitor: every consumed result must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_output", $signed(bus.out_val), -9999);
            end else begin
                chk("sb_out_val", $signed(bus.out_val), sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // Called at posedge+1; leaves in_valid high so calls chain back-to-back.
    task automatic send(input int s);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_val   = 7'(s);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("in_ready_wait", ok, 1);
        if (ok && s < 100) sb.push_back(model_step(s));
        if (!ok) bus.in_valid = 1'b0;
        step();
    endtask

    task automatic pulse_clr();
        idle();
        cycles(2);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_val    = '0;
        bus.out_ready = 1'b1;
        model_clear();

        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_val", $signed(bus.out_val), 0);
        chk("rst_err", bus.err, 0);
        chk("rst_sat", bus.sat, 0);
        chk("rst_wrap_cnt", bus.wrap_cnt, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // First sample seeds the accumulator
        send(45);
        idle();
        @(negedge clk);
        chk("first_out_valid", bus.out_valid, 1);
        chk("first_out_val", $signed(bus.out_val), 45);
        chk("first_sat", bus.sat, 0);
        chk("first_err", bus.err, 0);
        step();

        // Upward wrap 95 -> 5 continues to 105
        send(85);
        send(95);
        send(5);
        idle();
        cycles(2);
        chk("wrap_up_cnt", bus.wrap_cnt, STATS ? m_wraps : 0);

        // Downward wrap 5 -> 95 gives -5
        pulse_clr();
        send(5);
        send(95);
        idle();
        cycles(2);
        chk("wrap_dn_cnt", bus.wrap_cnt, STATS ? m_wraps : 0);

        // |delta| == 50 is taken literally
        pulse_clr();
        chk("clr_wrap_cnt", bus.wrap_cnt, 0);
        send(0);
        send(50);
        send(0);
        idle();
        cycles(2);
        chk("th_wrap_cnt", bus.wrap_cnt, 0);
        chk("th_sat", bus.sat, 0);

        // Backpressure: result held, next sample stalled
        bus.out_ready = 1'b0;
        send(30);
        bus.in_val = 7'd40;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_out_val", $signed(bus.out_val), 30);
            step();
        end
        bus.out_ready = 1'b1;
        send(40);
        idle();
        cycles(2);

        // Illegal sample: err pulse, no output, history kept
        send(5);
        send(120);
        idle();
        @(negedge clk);
        chk("ill_err_pulse", bus.err, 1);
        chk("ill_out_valid", bus.out_valid, 0);
        step();
        @(negedge clk);
        chk("ill_err_clear", bus.err, 0);
        step();
        send(12);
        idle();
        @(negedge clk);
        chk("ill_next_val", $signed(bus.out_val), 12);
        step();

        // Positive saturation, then a delta applied from the clamp
        pulse_clr();
        for (int i = 0; i < 16; i++) send((40 * i) % 100);
        idle();
        @(negedge clk);
        chk("sat_hi_val", $signed(bus.out_val), 511);
        chk("sat_hi_flag", bus.sat, 1);
        step();
        send(60);
        idle();
        cycles(2);
        chk("sat_sticky", bus.sat, m_sat);

        // clr beats a same-cycle sample
        bus.clr      = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_val   = 7'd33;
        @(negedge clk);
        chk("clr_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
        model_clear();
        @(negedge clk);
        chk("clr_sat", bus.sat, 0);
        chk("clr_out_valid", bus.out_valid, 0);
        step();
        send(7);
        idle();
        @(negedge clk);
        chk("after_clr_val", $signed(bus.out_val), 7);
        chk("after_clr_sat", bus.sat, 0);
        step();

        // Negative saturation
        pulse_clr();
        for (int i = 0; i < 16; i++) send((100 - (40 * i) % 100) % 100);
        idle();
        @(negedge clk);
        chk("sat_lo_val", $signed(bus.out_val), -512);
        chk("sat_lo_flag", bus.sat, 1);
        step();
        cycles(2);

        // Asynchronous reset drops a pending result immediately
        bus.out_ready = 1'b0;
        send(50);
        idle();
        @(negedge clk);
        chk("pend_out_valid", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_sat", bus.sat, 0);
        chk("arst_out_val", $signed(bus.out_val), 0);
        sb.delete();
        model_clear();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        send(9);
        idle();
        @(negedge clk);
        chk("post_rst_val", $signed(bus.out_val), 9);
        step();

        cycles(3);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/range_unwrapper.md
Name: range_unwrapper

Overview:
- Inverse of the modulo-100 range reduction stage.
- Accepts a stream of wrapped values in 0..99 and reconstructs a continuous signed 10-bit value.
- Infers each wrap-around from the shortest-path difference between consecutive samples and keeps a running accumulator.
- Sits downstream of the 7-bit adjusted-value path, where the unwrapped nf-style value must be recovered.

Parameters:
- MOD, 100, modulus of the wrapped input domain.
- WRAP_TH, 50, largest difference magnitude taken literally. Any |delta| > WRAP_TH is corrected by ±MOD.
- DW_IN, 7, input value width.
- DW_OUT, 10, output width, signed two's complement.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear back to the no-history state.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_val  input  DW_IN  wrapped sample; legal range 0..MOD-1.
- out_valid  output  1  out_val holds a result.
- out_ready  input  1  consumer accepts out_val.
- out_val  output  DW_OUT  signed unwrapped value.
- err  output  1  one-cycle pulse when an illegal sample (>= MOD) is consumed.
- sat  output  1  sticky flag: accumulator has clamped.
- wrap_cnt  output  8  wrap-correction count (feature-dependent, see below).

Behaviour:
- Reset (rst_n low, asynchronous): state=EMPTY; acc=0, prev=0; out_valid=0, out_val=0; err=0, sat=0, wrap_cnt=0.
- Handshake:
  - in_ready = !clr && (!out_valid || out_ready).
  - A sample is accepted when in_valid && in_ready.
  - out_val is held stable while out_valid && !out_ready.
- Latency: result is registered. out_valid rises the cycle after acceptance. Back-to-back throughput is 1 sample/cycle while out_ready=1.
- State EMPTY (no history):
  - Legal sample s: acc=s, prev=s, out_val=s, then go to TRACK.
- State TRACK:
  - delta = s - prev, computed as a signed 8-bit value.
  - If delta > WRAP_TH, then delta -= MOD. If delta < -WRAP_TH, then delta += MOD. |delta| == WRAP_TH is taken literally.
  - acc_next = acc + delta, computed in DW_OUT+1 bits, then clamped to [-512, 511].
  - If clamping occurs, sat=1.
  - prev=s; out_val=acc_next.
- Illegal sample (in_val >= MOD):
  - The sample is consumed (handshake completes).
  - err pulses high for exactly one cycle after acceptance.
  - No out_valid is produced; acc, prev and state are unchanged.
- Saturation:
  - acc stays clamped; later deltas apply from the clamped value.
  - sat stays 1 until clr or reset.
- clr:
  - Takes priority over a same-cycle in_valid; in_ready=0, so the sample is not accepted.
  - Next cycle: state=EMPTY, acc=0, sat=0, wrap_cnt=0, out_valid=0. Any pending output is dropped.
- Mid-operation reset: asynchronous, clears everything immediately, including a pending output.

Optional Feature:
- RANGE_UNWRAP_STATS_EN defined:
  - wrap_cnt increments on every ±MOD correction.
  - Saturates at 255; cleared by clr or reset.
- RANGE_UNWRAP_STATS_EN not defined:
  - wrap_cnt is tied to 0; no counter logic is built.

Test Plan:
- Reset, then send 45 → one cycle later out_valid=1, out_val=45, sat=0, err=0.
- Send 85, 95, 5 (out_ready=1) → out_val 85, 95, 105; wrap_cnt=1 with the feature enabled.
- Send 5, 95 → out_val 5, -5. Then send 0, 50, 0 after clr → out_val 0, 50, 0 with no correction.
- Hold out_ready=0 after sample 30, with in_valid=1 and in_val=40 → in_ready=0 and out_val holds 30. Raise out_ready → 40 accepted, next out_val=40.
- Send 120 → err pulses once, out_valid stays 0. Next sample 12 (prev=5) → out_val reflects delta +7 from the prior acc.
- Repeat 0, 40, 80, 20, 60 … until acc exceeds 511 → out_val=511, sat=1. Assert clr together with in_valid → sample not accepted. Then send 7 → out_val=7, sat=0.
